// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank.
// Holds the counting mode selectors, the channel assignments used by the CPU,
// and the index-width helper used by the bank and its interface.
package perf_pkg;

    // Counting modes
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Channel assignments used by the CPU core
    localparam int unsigned CH_CYCLES  = 0;
    localparam int unsigned CH_INSTRET = 1;
    localparam int unsigned CH_BRANCH  = 2;
    localparam int unsigned CH_STALL   = 3;

    // Index bus width; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control and readback bus of the performance counter bank.
// master: the debug/CPU side that drives controls and reads results.
// slave : the counter bank.
// Signals: run, inc, clear_all, clr_en/clr_idx, load_en/load_idx/load_val,
//          snap, rd_idx, rd_shadow (to the bank); rd_data, ovf, snap_valid
//          (from the bank).
interface perf_counter_bank_if
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
);
    logic              run;
    logic [NUM_CH-1:0] inc;
    logic              clear_all;
    logic              clr_en;
    logic [IDX_W-1:0]  clr_idx;
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic [WIDTH-1:0]  load_val;
    logic              snap;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_shadow;
    logic [WIDTH-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;
    logic              snap_valid;

    modport master (
        output run, inc, clear_all, clr_en, clr_idx, load_en, load_idx,
               load_val, snap, rd_idx, rd_shadow,
        input  rd_data, ovf, snap_valid
    );

    modport slave (
        input  run, inc, clear_all, clr_en, clr_idx, load_en, load_idx,
               load_val, snap, rd_idx, rd_shadow,
        output rd_data, ovf, snap_valid
    );
endinterface

// File: rtl/perf_counter_cell.sv
// One counter channel: live counter, sticky overflow flag and shadow copy.
// Ports: clk, rst (sync, active-high); i_clr, i_ld/i_ld_val, i_inc_en, i_snap
//        (already decoded for this channel, i_clr highest priority);
//        o_cnt, o_shadow, o_ovf (all registered).
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_inc_en,
    input  logic             i_snap,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_shadow,
    output logic             o_ovf
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic             r_ovf;

    // Counter, overflow and shadow update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // Shadow takes the pre-edge count, unaffected by this cycle's update
            if (i_snap) begin
                r_shadow <= r_cnt;
            end
            if (i_clr) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (i_ld) begin
                r_cnt <= i_ld_val;
                r_ovf <= 1'b0;
            end else if (i_inc_en) begin
                if (r_cnt == {WIDTH{1'b1}}) begin
                    r_ovf <= 1'b1;
                    if (SATURATE != MODE_SAT) begin
                        r_cnt <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;
endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with snapshot and indexed registered readback.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying run, inc,
//        clear/load controls, snap, read index/source select, and the
//        registered rd_data, sticky ovf flags and snap_valid.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SATURATE = MODE_WRAP,
    parameter int unsigned IDX_W    = idx_width(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst,
    perf_counter_bank_if.slave bus
);
    logic [WIDTH-1:0]  w_cnt    [NUM_CH];
    logic [WIDTH-1:0]  w_shadow [NUM_CH];
    logic [NUM_CH-1:0] w_ovf;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_snap_valid;

    // Per-channel control decode; out-of-range indices match no channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_clr;
        logic w_ld;
        logic w_inc_en;

        assign w_clr    = bus.clear_all | (bus.clr_en & (bus.clr_idx == IDX_W'(g)));
        assign w_ld     = bus.load_en & (bus.load_idx == IDX_W'(g));
        assign w_inc_en = bus.run & bus.inc[g];

        perf_counter_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (w_clr),
            .i_ld     (w_ld),
            .i_ld_val (bus.load_val),
            .i_inc_en (w_inc_en),
            .i_snap   (bus.snap),
            .o_cnt    (w_cnt[g]),
            .o_shadow (w_shadow[g]),
            .o_ovf    (w_ovf[g])
        );
    end

    // Registered read mux; out-of-range index reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (32'(bus.rd_idx) >= NUM_CH) begin
            r_rd_data <= '0;
        end else if (bus.rd_shadow) begin
            r_rd_data <= w_shadow[bus.rd_idx];
        end else begin
            r_rd_data <= w_cnt[bus.rd_idx];
        end
    end

    // Sticky indication that a snapshot exists
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid <= 1'b0;
        end else if (bus.snap) begin
            r_snap_valid <= 1'b1;
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.ovf        = w_ovf;
    assign bus.snap_valid = r_snap_valid;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench: two banks (4 ch wrap, 3 ch saturate, both 8-bit) driven by the
// same stimulus; a reference model predicts each cycle's outputs into a queue
// that a monitor drains and compares.
module tb_perf_counter_bank;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(8), .IDX_W(2)) ifa ();
    perf_counter_bank_if #(.NUM_CH(3), .WIDTH(8), .IDX_W(2)) ifb ();

    perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(MODE_WRAP), .IDX_W(2)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .SATURATE(MODE_SAT), .IDX_W(2)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    typedef struct packed {
        logic       rst;
        logic       run;
        logic [3:0] inc;
        logic       clear_all;
        logic       clr_en;
        logic [1:0] clr_idx;
        logic       load_en;
        logic [1:0] load_idx;
        logic [7:0] load_val;
        logic       snap;
        logic [1:0] rd_idx;
        logic       rd_shadow;
    } stim_t;

    typedef struct packed {
        logic [7:0] rd_a;
        logic [3:0] ovf_a;
        logic       sv_a;
        logic [7:0] rd_b;
        logic [2:0] ovf_b;
        logic       sv_b;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: [bank][channel]
    logic [7:0] m_cnt [2][4];
    logic [7:0] m_sh  [2][4];
    logic       m_ovf [2][4];
    logic       m_sv  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and predict the outputs after the next edge
    task automatic drive(input stim_t s);
        exp_t       e;
        int         n;
        logic [7:0] rdv;
        @(negedge clk);
        rst           = s.rst;
        ifa.run       = s.run;        ifb.run       = s.run;
        ifa.inc       = s.inc;        ifb.inc       = s.inc[2:0];
        ifa.clear_all = s.clear_all;  ifb.clear_all = s.clear_all;
        ifa.clr_en    = s.clr_en;     ifb.clr_en    = s.clr_en;
        ifa.clr_idx   = s.clr_idx;    ifb.clr_idx   = s.clr_idx;
        ifa.load_en   = s.load_en;    ifb.load_en   = s.load_en;
        ifa.load_idx  = s.load_idx;   ifb.load_idx  = s.load_idx;
        ifa.load_val  = s.load_val;   ifb.load_val  = s.load_val;
        ifa.snap      = s.snap;       ifb.snap      = s.snap;
        ifa.rd_idx    = s.rd_idx;     ifb.rd_idx    = s.rd_idx;
        ifa.rd_shadow = s.rd_shadow;  ifb.rd_shadow = s.rd_shadow;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 4 : 3;
            if (s.rst) begin
                for (int c = 0; c < 4; c++) begin
                    m_cnt[d][c] = 8'd0;
                    m_sh[d][c]  = 8'd0;
                    m_ovf[d][c] = 1'b0;
                end
                m_sv[d] = 1'b0;
                rdv     = 8'd0;
            end else begin
                if (int'(s.rd_idx) >= n)  rdv = 8'd0;
                else if (s.rd_shadow)     rdv = m_sh[d][s.rd_idx];
                else                      rdv = m_cnt[d][s.rd_idx];
                for (int c = 0; c < n; c++) begin
                    if (s.snap) m_sh[d][c] = m_cnt[d][c];
                    if (s.clear_all || (s.clr_en && int'(s.clr_idx) == c)) begin
                        m_cnt[d][c] = 8'd0;
                        m_ovf[d][c] = 1'b0;
                    end else if (s.load_en && int'(s.load_idx) == c) begin
                        m_cnt[d][c] = s.load_val;
                        m_ovf[d][c] = 1'b0;
                    end else if (s.run && s.inc[c]) begin
                        if (m_cnt[d][c] == 8'hFF) begin
                            m_ovf[d][c] = 1'b1;
                            m_cnt[d][c] = (d == 1) ? 8'hFF : 8'h00;
                        end else begin
                            m_cnt[d][c] = m_cnt[d][c] + 8'd1;
                        end
                    end
                end
                if (s.snap) m_sv[d] = 1'b1;
            end
            if (d == 0) e.rd_a = rdv; else e.rd_b = rdv;
        end
        for (int c = 0; c < 4; c++) e.ovf_a[c] = m_ovf[0][c];
        for (int c = 0; c < 3; c++) e.ovf_b[c] = m_ovf[1][c];
        e.sv_a = m_sv[0];
        e.sv_b = m_sv[1];
        q.push_back(e);
    endtask

    // Monitor: one prediction per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("a_rd_data",    32'(ifa.rd_data),    32'(e.rd_a));
            chk("a_ovf",        32'(ifa.ovf),        32'(e.ovf_a));
            chk("a_snap_valid", 32'(ifa.snap_valid), 32'(e.sv_a));
            chk("b_rd_data",    32'(ifb.rd_data),    32'(e.rd_b));
            chk("b_ovf",        32'(ifb.ovf),        32'(e.ovf_b));
            chk("b_snap_valid", 32'(ifb.snap_valid), 32'(e.sv_b));
        end
    end

    // Wait for the edge following the last drive, then sample
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        stim_t s;
        int    guard;

        // 1: reset then count channel 0
        s = '0; s.rst = 1'b1;
        drive(s); drive(s);
        s = '0; s.run = 1'b1; s.inc = 4'b0001;
        repeat (10) drive(s);
        s = '0;
        drive(s);
        settle();
        chk("t1_ch0_is_10", 32'(ifa.rd_data), 32'd10);
        s.rd_idx = 2'd1; drive(s);
        s.rd_idx = 2'd3; drive(s);

        // 2: wrap on channel 1
        s = '0; s.load_en = 1'b1; s.load_idx = 2'd1; s.load_val = 8'hFE; s.rd_idx = 2'd1;
        drive(s);
        s = '0; s.run = 1'b1; s.inc = 4'b0010; s.rd_idx = 2'd1;
        repeat (3) drive(s);
        s = '0; s.rd_idx = 2'd1;
        drive(s);
        settle();
        chk("t2_wrap_value", 32'(ifa.rd_data), 32'h01);
        chk("t2_wrap_ovf1",  32'(ifa.ovf[1]),  32'd1);
        chk("t2_sat_value",  32'(ifb.rd_data), 32'hFF);
        s = '0; s.load_en = 1'b1; s.load_idx = 2'd1; s.load_val = 8'h10;
        drive(s);
        settle();
        chk("t2_load_clears_ovf1", 32'(ifa.ovf[1]), 32'd0);

        // 3: saturate on channel 2
        s = '0; s.load_en = 1'b1; s.load_idx = 2'd2; s.load_val = 8'hFE;
        drive(s);
        s = '0; s.run = 1'b1; s.inc = 4'b0100; s.rd_idx = 2'd2;
        repeat (5) drive(s);
        s = '0; s.rd_idx = 2'd2;
        drive(s);
        settle();
        chk("t3_sat_hold", 32'(ifb.rd_data), 32'hFF);
        chk("t3_sat_ovf2", 32'(ifb.ovf[2]),  32'd1);
        s = '0; s.clr_en = 1'b1; s.clr_idx = 2'd2; s.rd_idx = 2'd2;
        drive(s);
        s = '0; s.rd_idx = 2'd2;
        drive(s);
        settle();
        chk("t3_clr_value", 32'(ifb.rd_data), 32'd0);
        chk("t3_clr_ovf2",  32'(ifb.ovf[2]),  32'd0);

        // 4: snapshot taken in the same cycle as clear_all
        s = '0; s.load_en = 1'b1; s.load_idx = 2'd0; s.load_val = 8'd100;
        drive(s);
        s.load_idx = 2'd3; s.load_val = 8'd7;
        drive(s);
        s = '0; s.run = 1'b1; s.inc = 4'b1001; s.snap = 1'b1; s.clear_all = 1'b1;
        drive(s);
        s = '0; s.rd_idx = 2'd3; s.rd_shadow = 1'b1;
        drive(s);
        settle();
        chk("t4_shadow3", 32'(ifa.rd_data),    32'd7);
        chk("t4_snap_vl", 32'(ifa.snap_valid), 32'd1);
        s.rd_idx = 2'd0; drive(s);
        settle();
        chk("t4_shadow0", 32'(ifa.rd_data), 32'd100);
        s.rd_shadow = 1'b0; drive(s);
        settle();
        chk("t4_live0_cleared", 32'(ifa.rd_data), 32'd0);

        // 5: clear beats load beats increment; load drops increment
        s = '0; s.run = 1'b1; s.inc = 4'b0010; s.clr_en = 1'b1; s.clr_idx = 2'd1;
        s.load_en = 1'b1; s.load_idx = 2'd1; s.load_val = 8'd55;
        drive(s);
        s = '0; s.rd_idx = 2'd1;
        drive(s);
        settle();
        chk("t5_clear_wins", 32'(ifa.rd_data), 32'd0);
        s = '0; s.run = 1'b1; s.inc = 4'b0010; s.load_en = 1'b1; s.load_idx = 2'd1;
        s.load_val = 8'd55;
        drive(s);
        s = '0; s.rd_idx = 2'd1;
        drive(s);
        settle();
        chk("t5_load_wins", 32'(ifa.rd_data), 32'd55);

        // 6: freeze, then reset mid-count, then out-of-range read
        s = '0; s.inc = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            s.rd_idx = 2'(i);
            drive(s);
        end
        s = '0; s.run = 1'b1; s.inc = 4'b1111; s.snap = 1'b1;
        repeat (3) drive(s);
        s.rst = 1'b1;
        drive(s);
        settle();
        chk("t6_rst_rd",   32'(ifa.rd_data),    32'd0);
        chk("t6_rst_ovf",  32'(ifa.ovf),        32'd0);
        chk("t6_rst_snap", 32'(ifa.snap_valid), 32'd0);
        s = '0; s.rd_idx = 2'd3; s.rd_shadow = 1'b1;
        drive(s);
        s = '0; s.load_en = 1'b1; s.load_idx = 2'd3; s.load_val = 8'hAA; s.rd_idx = 2'd3;
        drive(s);
        s = '0; s.rd_idx = 2'd3;
        drive(s);
        settle();
        chk("t6_oob_read_b", 32'(ifb.rd_data), 32'd0);

        // Randomised traffic, biased toward the wrap/saturate boundary
        for (int i = 0; i < 600; i++) begin
            s = '0;
            s.rst       = ($urandom_range(0, 99) == 0);
            s.run       = ($urandom_range(0, 4) != 0);
            s.inc       = 4'($urandom);
            s.clear_all = ($urandom_range(0, 39) == 0);
            s.clr_en    = ($urandom_range(0, 9) == 0);
            s.clr_idx   = 2'($urandom);
            s.load_en   = ($urandom_range(0, 5) == 0);
            s.load_idx  = 2'($urandom);
            s.load_val  = ($urandom_range(0, 2) == 0) ? 8'(8'hFD + $urandom_range(0, 2))
                                                       : 8'($urandom);
            s.snap      = ($urandom_range(0, 11) == 0);
            s.rd_idx    = 2'($urandom);
            s.rd_shadow = 1'($urandom);
            drive(s);
        end

        // Drain outstanding predictions, bounded
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
